// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the M-stage memory responder:
//   - FSM state encoding (IDLE / WAIT / RESP)
//   - byte-enable patterns that carry alignment rules
//   - default geometry and latency
//   - the latched request record and a byte-merge helper
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] BE_WORD = 4'hF;
    localparam logic [3:0] BE_HLO  = 4'h3;
    localparam logic [3:0] BE_HHI  = 4'hC;

    localparam int unsigned DEFAULT_DEPTH = 1024;
    localparam int unsigned DEFAULT_LAT   = 2;

    // Request fields captured on the accept edge.
    typedef struct packed {
        logic        write;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } req_t;

    // Replace the byte lanes of old_word selected by be with those of new_word.
    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] w;
        w = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                w[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// DEPTH x 32-bit word storage with per-byte write enables, a registered read
// port and asynchronous clear of every word.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low clear of storage and read register
//   we_i     write strobe; bytes selected by be_i are updated at addr_i
//   be_i     byte enables for the write
//   addr_i   word index shared by read and write
//   wdata_i  write data, byte lanes already positioned
//   re_i     read strobe; mem[addr_i] is captured into rdata_o
//   rdata_o  registered read data, held until the next read
// -----------------------------------------------------------------------------
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[addr_i] <= merge_word(mem_q[addr_i], wdata_i, be_i);
            end
            if (re_i) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Handshaked word memory behind the M-stage data port. One load/store is in
// flight at a time; the access commits LAT cycles after acceptance and the
// response is presented for exactly one cycle. stall freezes the pipeline
// while a request is being presented or is outstanding.
// Ports:
//   clk_i         clock, all state changes on the rising edge
//   rst_ni        asynchronous active-low reset (aborts any in-flight request)
//   req_valid_i   a load or store is presented
//   req_write_i   1 = store, 0 = load
//   req_be_i      store byte enables (loads always check as a full word)
//   req_addr_i    byte address
//   req_wdata_i   store data, lanes already positioned
//   req_pc_i      PC of the requester, used by the write trace only
//   req_ready_o   request can be accepted this cycle
//   resp_valid_o  one-cycle completion pulse
//   resp_rdata_o  load data, zero unless resp_valid_o
//   resp_err_o    address fault, zero unless resp_valid_o
//   stall_o       pipeline freeze request
// -----------------------------------------------------------------------------
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned LAT   = DEFAULT_LAT,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [3:0]  req_be_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [31:0] req_pc_i,
    output logic        req_ready_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        stall_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    // Size of the mapped window in bytes, one bit wider so DEPTH*4 never wraps.
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;
    logic        err_q, err_d;

    logic [31:0] off;
    logic [3:0]  chk_be;
    logic        range_fault;
    logic        align_fault;
    logic        be_fault;
    logic        fault;
    logic        commit;
    logic        mem_we;
    logic        mem_re;
    logic [AW-1:0] word_idx;
    logic [31:0] mem_rdata;

    // ---------------------------------------------------------------------
    // Address decode on the latched request
    // ---------------------------------------------------------------------
    always_comb begin
        off         = req_q.addr - BASE;
        // Loads are checked as full-word accesses regardless of req_be.
        chk_be      = req_q.write ? req_q.be : BE_WORD;
        range_fault = ({1'b0, off} >= SPAN);
        align_fault = ((chk_be == BE_WORD) && (off[1:0] != 2'b00)) ||
                      (((chk_be == BE_HLO) || (chk_be == BE_HHI)) && off[0]);
        be_fault    = req_q.write && (req_q.be == 4'h0);
        fault       = range_fault || align_fault || be_fault;
        word_idx    = off[AW+1:2];
    end

    assign commit = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign mem_we = commit && req_q.write && !fault;
    assign mem_re = commit && !req_q.write && !fault;

    // ---------------------------------------------------------------------
    // FSM and latency counter
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    req_d.write = req_write_i;
                    req_d.be    = req_be_i;
                    req_d.addr  = req_addr_i;
                    req_d.wdata = req_wdata_i;
                    req_d.pc    = req_pc_i;
                    cnt_d       = 4'(LAT - 1);
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    err_d   = fault;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            err_q   <= err_d;
        end
    end

    // ---------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------
    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (mem_we),
        .be_i    (req_q.be),
        .addr_i  (word_idx),
        .wdata_i (req_q.wdata),
        .re_i    (mem_re),
        .rdata_o (mem_rdata)
    );

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        req_ready_o  = (state_q == ST_IDLE);
        resp_valid_o = (state_q == ST_RESP);
        resp_err_o   = resp_valid_o && err_q;
        // The array read register holds stale data between loads; only a
        // clean load response may expose it.
        resp_rdata_o = (resp_valid_o && !req_q.write && !err_q) ? mem_rdata : 32'h0;
        // Zero in RESP so the pipeline advances on the edge that takes the data.
        stall_o      = ((state_q == ST_IDLE) && req_valid_i) || (state_q == ST_WAIT);
    end

`ifndef SYNTHESIS
    // Store trace; the old word is read before the commit edge updates it.
    always @(posedge clk_i) begin
        if (rst_ni && mem_we) begin
            $display("@%h: *%h <= %h", req_q.pc, {req_q.addr[31:2], 2'b00},
                     merge_word(u_array.mem_q[word_idx], req_q.wdata, req_q.be));
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Two responders (LAT = 2 and LAT = 1) driven independently. A transaction-
// level model predicts every output on every cycle; directed cases pin the
// model with literal values, then randomized traffic exercises both.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT0  = 2;
    localparam int LAT1  = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic        req_valid  [2];
    logic        req_write  [2];
    logic [3:0]  req_be     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [31:0] req_pc     [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic        stall      [2];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(DEPTH), .LAT(LAT0), .BASE(32'h0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[0]), .req_write_i(req_write[0]), .req_be_i(req_be[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_pc_i(req_pc[0]),
        .req_ready_o(req_ready[0]), .resp_valid_o(resp_valid[0]),
        .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0]), .stall_o(stall[0])
    );

    mem_responder #(.DEPTH(DEPTH), .LAT(LAT1), .BASE(32'h0)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[1]), .req_write_i(req_write[1]), .req_be_i(req_be[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_pc_i(req_pc[1]),
        .req_ready_o(req_ready[1]), .resp_valid_o(resp_valid[1]),
        .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1]), .stall_o(stall[1])
    );

    // ---------------------------------------------------------------------
    // Reference model: per instance, edges elapsed since acceptance
    // (-1 = idle), the accepted request and a plain word array.
    // ---------------------------------------------------------------------
    bit [31:0] mm [2][DEPTH];
    int        k  [2];
    bit        a_write [2];
    bit [3:0]  a_be    [2];
    bit [31:0] a_addr  [2];
    bit [31:0] a_wdata [2];
    bit [31:0] m_rdata [2];
    bit        m_err   [2];
    bit        prev_v  [2];

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    function automatic bit model_fault(input bit w, input bit [3:0] be, input bit [31:0] addr);
        bit [3:0] ebe;
        ebe = w ? be : 4'hF;
        if (addr >= 32'(DEPTH * 4)) return 1'b1;
        if (ebe == 4'hF && addr[1:0] != 2'b00) return 1'b1;
        if ((ebe == 4'h3 || ebe == 4'hC) && addr[0]) return 1'b1;
        if (ebe == 4'h0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit [31:0] model_merge(input bit [31:0] o, input bit [31:0] n,
                                              input bit [3:0] be);
        bit [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            k[i] = -1;
            m_rdata[i] = '0;
            m_err[i] = 1'b0;
            for (int w = 0; w < DEPTH; w++) mm[i][w] = '0;
        end
    endtask

    task automatic model_step(input int i);
        bit f;
        int widx;
        if (k[i] < 0) begin
            if (req_valid[i] === 1'b1) begin
                a_write[i] = req_write[i];
                a_be[i]    = req_be[i];
                a_addr[i]  = req_addr[i];
                a_wdata[i] = req_wdata[i];
                k[i] = 1;
            end
        end else if (k[i] <= lat_of(i)) begin
            if (k[i] == lat_of(i)) begin
                f = model_fault(a_write[i], a_be[i], a_addr[i]);
                widx = int'(a_addr[i] >> 2) % DEPTH;
                m_err[i] = f;
                m_rdata[i] = (!a_write[i] && !f) ? mm[i][widx] : 32'h0;
                if (a_write[i] && !f) mm[i][widx] = model_merge(mm[i][widx], a_wdata[i], a_be[i]);
            end
            k[i] = k[i] + 1;
        end else begin
            k[i] = -1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    task automatic cmp(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, i, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the rising edge.
    initial begin
        for (int i = 0; i < 2; i++) prev_v[i] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                bit idle, busy, resp;
                idle = (k[i] < 0);
                busy = !idle && (k[i] <= lat_of(i));
                resp = (k[i] == lat_of(i) + 1);
                cmp("req_ready", i, 32'(req_ready[i]), 32'(idle));
                cmp("stall", i, 32'(stall[i]), 32'((idle && req_valid[i] === 1'b1) || busy));
                cmp("resp_valid", i, 32'(resp_valid[i]), 32'(resp));
                cmp("resp_rdata", i, resp_rdata[i], resp ? m_rdata[i] : 32'h0);
                cmp("resp_err", i, 32'(resp_err[i]), 32'(resp && m_err[i]));
                cmp("resp_pulse", i, 32'(prev_v[i] && resp_valid[i] === 1'b1), 32'h0);
                prev_v[i] = (resp_valid[i] === 1'b1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Driver: called just after a rising edge. Garbage (and random valid) is
    // driven while the request is outstanding to show it is ignored.
    // ---------------------------------------------------------------------
    task automatic send(input int i, input bit w, input bit [3:0] be, input bit [31:0] addr,
                        input bit [31:0] data, output int lat_cyc, output int stall_cyc,
                        output bit [31:0] rd, output bit er);
        int guard;
        guard = 0;
        lat_cyc = 0; stall_cyc = 0; rd = '0; er = 1'b0;
        while (req_ready[i] !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (req_ready[i] !== 1'b1) begin
            cmp("ready_timeout", i, 32'(req_ready[i]), 32'h1);
            return;
        end
        req_write[i] = w; req_be[i] = be; req_addr[i] = addr; req_wdata[i] = data;
        req_pc[i] = $urandom; req_valid[i] = 1'b1;
        #1 stall_cyc = int'(stall[i]);
        @(posedge clk); #1;
        lat_cyc = 1;
        while (resp_valid[i] !== 1'b1 && lat_cyc < 40) begin
            req_valid[i] = 1'($urandom_range(0, 1));
            req_write[i] = 1'($urandom); req_be[i] = 4'($urandom);
            req_addr[i] = $urandom; req_wdata[i] = $urandom;
            stall_cyc += int'(stall[i]);
            @(posedge clk); #1;
            lat_cyc++;
        end
        req_valid[i] = 1'b0;
        if (resp_valid[i] !== 1'b1) cmp("resp_timeout", i, 32'(resp_valid[i]), 32'h1);
        rd = resp_rdata[i];
        er = resp_err[i];
        @(posedge clk); #1;
    endtask

    logic [3:0] be_tab [9] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h6};

    initial begin
        int lc, sc, t, r1, r2;
        bit [31:0] rd;
        bit er;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_be[i] = 4'h0;
            req_addr[i] = '0; req_wdata[i] = '0; req_pc[i] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_ready", 0, 32'(req_ready[0]), 32'h1);
        cmp("rst_valid", 0, 32'(resp_valid[0]), 32'h0);
        cmp("rst_stall", 0, 32'(stall[0]), 32'h0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Store / load round trip, LAT = 2
        send(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lc, sc, rd, er);
        cmp("st_latency", 0, lc, 3);
        cmp("st_stall_cycles", 0, sc, 3);
        cmp("st_err", 0, 32'(er), 32'h0);
        send(0, 1'b0, 4'h0, 32'h10, 32'h0, lc, sc, rd, er);
        cmp("ld_latency", 0, lc, 3);
        cmp("ld_data", 0, rd, 32'hDEADBEEF);
        cmp("ld_err", 0, 32'(er), 32'h0);

        // Half-word merge
        send(0, 1'b1, 4'h3, 32'h10, 32'h0000_1234, lc, sc, rd, er);
        cmp("model_merge", 0, mm[0][4], 32'hDEAD1234);
        send(0, 1'b0, 4'h0, 32'h10, 32'h0, lc, sc, rd, er);
        cmp("ld_merged", 0, rd, 32'hDEAD1234);

        // Faults
        send(0, 1'b0, 4'hF, 32'h1000, 32'h0, lc, sc, rd, er);
        cmp("range_err", 0, 32'(er), 32'h1);
        cmp("range_rdata", 0, rd, 32'h0);
        send(0, 1'b1, 4'hF, 32'h12, 32'hFFFF_FFFF, lc, sc, rd, er);
        cmp("misalign_err", 0, 32'(er), 32'h1);
        send(0, 1'b0, 4'h0, 32'h10, 32'h0, lc, sc, rd, er);
        cmp("mem_unchanged", 0, rd, 32'hDEAD1234);

        // Back-to-back with req_valid held high
        req_write[0] = 1'b1; req_be[0] = 4'hF; req_addr[0] = 32'h30;
        req_wdata[0] = 32'h600DCAFE; req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_write[0] = 1'b0; req_addr[0] = 32'h30; req_wdata[0] = 32'h0;
        t = 1;
        while (resp_valid[0] !== 1'b1 && t < 40) begin @(posedge clk); #1; t++; end
        r1 = t;
        @(posedge clk); #1; t++;
        cmp("b2b_idle_ready", 0, 32'(req_ready[0]), 32'h1);
        @(posedge clk); #1; t++;
        req_valid[0] = 1'b0;
        while (resp_valid[0] !== 1'b1 && t < 80) begin @(posedge clk); #1; t++; end
        r2 = t;
        cmp("b2b_gap", 0, r2 - r1, 4);
        cmp("b2b_data", 0, resp_rdata[0], 32'h600DCAFE);
        @(posedge clk); #1;

        // Reset during WAIT of a store
        send(0, 1'b1, 4'hF, 32'h20, 32'h55AA55AA, lc, sc, rd, er);
        req_write[0] = 1'b1; req_be[0] = 4'hF; req_addr[0] = 32'h20;
        req_wdata[0] = 32'h1111_1111; req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        cmp("async_ready", 0, 32'(req_ready[0]), 32'h1);
        cmp("async_stall", 0, 32'(stall[0]), 32'h0);
        cmp("async_valid", 0, 32'(resp_valid[0]), 32'h0);
        cmp("async_rdata", 0, resp_rdata[0], 32'h0);
        cmp("async_err", 0, 32'(resp_err[0]), 32'h0);
        @(posedge clk); #2 rst_n = 1'b1;
        #1 cmp("post_rst_ready", 0, 32'(req_ready[0]), 32'h1);
        @(posedge clk); #1;
        send(0, 1'b0, 4'h0, 32'h20, 32'h0, lc, sc, rd, er);
        cmp("post_rst_load", 0, rd, 32'h0);

        // LAT = 1 instance
        send(1, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D, lc, sc, rd, er);
        cmp("lat1_latency", 1, lc, 2);
        cmp("lat1_stall_cycles", 1, sc, 2);
        send(1, 1'b0, 4'h0, 32'h40, 32'h0, lc, sc, rd, er);
        cmp("lat1_data", 1, rd, 32'hCAFEF00D);

        // Randomized traffic, both instances
        for (int n = 0; n < 250; n++) begin
            int i, r;
            bit [31:0] a;
            i = (n < 150) ? 0 : 1;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'h1000 + 32'($urandom_range(0, 255));
            else if (r < 6)  a = 32'($urandom_range(0, 15)) << 2;
            else             a = 32'($urandom_range(0, 63));
            send(i, 1'($urandom), be_tab[$urandom_range(0, 8)], a, $urandom, lc, sc, rd, er);
            cmp("rand_latency", i, lc, lat_of(i) + 1);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
